ring_fifo: RTL and testbench
============================

# ring_fifo

Parametrised single-clock circular FIFO for the UART datapath. It is the next generation of the UART receive buffer, with a command-driven read port. It adds:
- configurable overwrite or drop policy on full,
- occupancy and threshold flags,
- sticky error flags and a synchronous flush,
- an optional first-word-fall-through read mode.

It sits between the UART byte/word assembler (write side) and the core's memory-mapped UART read path (read side).

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 16, number of entries; any integer ≥2, power of two not required
- OVERWRITE, 1, 1: write when full replaces oldest entry; 0: write when full is dropped
- AFULL_LVL, DEPTH-2, almost_full asserted when count ≥ AFULL_LVL
- AEMPTY_LVL, 2, almost_empty asserted when count ≤ AEMPTY_LVL

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- write  in  1  push data_in this cycle
- data_in  in  WIDTH  write data
- read  in  1  pop request (UART read command decoded upstream)
- data_out  out  WIDTH  read data
- clear  in  1  synchronous flush
- err_clr  in  1  clears overflow and underflow
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AEMPTY_LVL
- almost_full  out  1  count ≥ AFULL_LVL
- overflow  out  1  sticky: write attempted while full without a simultaneous read
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×WIDTH array. Pointers wr_ptr and rd_ptr run 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. This is valid for non-power-of-two DEPTH.
- Priority per cycle: clear > read/write.
  - clear: wr_ptr, rd_ptr and count go to 0.
  - clear leaves data_out, overflow and underflow unchanged.
  - read and write in the same cycle as clear are ignored.
- Write, not full: store at wr_ptr, advance wr_ptr, count+1.
- Read, not empty: pop entry at rd_ptr, advance rd_ptr, count-1.
- Read when empty:
  - No pop; data_out ← 0; underflow set.
  - This applies even if write is high in the same cycle. There is no bypass; the write is still accepted.
- Read and write together when full: the pop and the push both occur; count stays at DEPTH; overflow is not set.
- Read and write together, 0 < count < DEPTH: both occur; count unchanged.
- Write when full, no read:
  - OVERWRITE=1: store at wr_ptr, advance both pointers, count stays DEPTH, overflow set.
  - OVERWRITE=0: no store, pointers unchanged, overflow set.
- err_clr clears both sticky flags. If an overflow or underflow event occurs in the same cycle, that flag is set, not cleared.
- Status outputs (empty, full, almost_empty, almost_full, count) are combinational from registered count only.

## Timing
- Reset (reset=0, asynchronous assert; deassert is synchronised externally). Values during and after reset:
  - pointers 0, count 0, data_out 0, overflow 0, underflow 0
  - outputs therefore: empty=1, full=0, almost_empty=1, almost_full=(AFULL_LVL==0)
  - array contents are don't-care
- Reset mid-operation discards all contents immediately; no partial update completes.
- Default (registered) read latency is 1:
  - data_out holds the popped word from the edge after read is sampled.
  - data_out holds its value when read=0.
- Status and count reflect an operation on the edge that samples it; they are valid in the following cycle.
- Write-to-read turnaround: a word written at edge N is poppable by a read sampled at edge N+1.

## Configuration
- RING_FIFO_FWFT_EN defined (first-word-fall-through):
  - data_out is combinational and equals the entry at rd_ptr whenever count>0; it is 0 when empty.
  - read pops that word at the edge, and data_out shows the next head in the same cycle the count update is visible.
  - Underflow behaviour is unchanged.
- RING_FIFO_FWFT_EN undefined: registered 1-cycle read latency as in Timing.

## Test plan
- Reset, then write 0x11,0x22,0x33, then three reads -> data_out 0x11,0x22,0x33 on successive cycles; count 3→0; empty=1 at the end; no flags set.
- DEPTH=16, OVERWRITE=1: write 0..16 (17 words), then 16 reads -> data 1..16; overflow=1; err_clr -> overflow=0.
- OVERWRITE=0, DEPTH=5: write 0xA0..0xA5 -> 0xA5 dropped; count=5, full=1, overflow=1; reads return 0xA0..0xA4.
- Empty FIFO, read and write (0x5A) in the same cycle -> data_out=0, underflow=1, count=1; next read returns 0x5A.
- Full FIFO, read and write together for 20 cycles, DEPTH=5 -> count stays 5, overflow=0, FIFO order preserved across pointer wrap.
- Fill to 8 with AFULL_LVL=8, assert clear with write high -> count=0, empty=1, almost_full 1→0; assert reset mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/ring_fifo_if.sv
// ring_fifo_if: bundle of the command, data and status signals between the
// ring_fifo and its users.
//
// Handshake semantics: there is no valid/ready pair. write and read are
// single-cycle commands sampled on the rising edge. The FIFO accepts every
// command it sees, and its policy decides the effect: drop or overwrite on
// full, underflow on empty. The status outputs tell the producer and the
// consumer what the next command will do.
//
// Parameters:
//   WIDTH  data word width
//   DEPTH  number of entries (sets the width of count)
//
// Modports:
//   master  drives write/data_in/read/clear/err_clr and observes data and status
//   slave   the FIFO side
interface ring_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             clear;
  logic             err_clr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output write, data_in, read, clear, err_clr,
    input  data_out, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );

  modport slave (
    input  write, data_in, read, clear, err_clr,
    output data_out, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );
endinterface

// File: rtl/ring_fifo.sv
// ring_fifo: single-clock circular FIFO between the UART word assembler
// (write side) and the memory-mapped UART read path (read side).
//
// Parameters:
//   WIDTH       data width
//   DEPTH       entries (>=2, any integer; the pointers wrap explicitly)
//   OVERWRITE   1: a write when full replaces the oldest entry
//               0: a write when full is dropped
//   AFULL_LVL   almost_full when count >= AFULL_LVL
//   AEMPTY_LVL  almost_empty when count <= AEMPTY_LVL
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ring_fifo_if.slave: write/data_in, read/data_out, clear, err_clr,
//          count, empty, full, almost_empty, almost_full, overflow, underflow
//
// Build option:
//   RING_FIFO_FWFT_EN  When defined, data_out is combinational and shows the
//                      head entry, or 0 when empty. When undefined, data_out
//                      is a register that is updated one edge after a read.
module ring_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int OVERWRITE  = 1,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  ring_fifo_if.slave   bus
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_LVL);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic is_empty;
  logic is_full;
  logic do_pop;       // a read that removes the head entry
  logic do_push;      // a write that stores data_in at wr_ptr
  logic rd_err;       // a read while empty
  logic wr_over;      // a write while full with no read to make room
  logic drop_oldest;  // wr_over with overwrite: the head is discarded

  // The pointers wrap explicitly, so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  // clear blocks every read and write decision in the same cycle.
  assign rd_err      = !bus.clear && bus.read && is_empty;
  assign do_pop      = !bus.clear && bus.read && !is_empty;
  assign wr_over     = !bus.clear && bus.write && is_full && !bus.read;
  assign drop_oldest = wr_over && (OVERWRITE != 0);
  // On full, a simultaneous read frees a slot, so the write still lands.
  // On empty, the write is accepted even though the read underflows.
  assign do_push     = !bus.clear && bus.write &&
                       (!is_full || bus.read || (OVERWRITE != 0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.clear) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (do_pop || drop_oldest) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        // An overwrite pushes one entry and drops one, so count holds at DEPTH.
        if (do_push && !do_pop && !drop_oldest) begin
          count_q <= count_q + CW'(1);
        end else if (do_pop && !do_push) begin
          count_q <= count_q - CW'(1);
        end
      end
      // A new event in the same cycle as err_clr leaves its flag set.
      if (wr_over) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end
      if (rd_err) begin
        underflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Storage has no reset. The contents are don't-care until they are written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

`ifdef RING_FIFO_FWFT_EN
  assign bus.data_out = is_empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] data_q;

  // data_q holds its value between reads and is not affected by clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (do_pop) begin
      data_q <= mem[rd_ptr];
    end else if (rd_err) begin
      data_q <= '0;
    end
  end

  assign bus.data_out = data_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_ring_fifo.sv
// tb_ring_fifo: drives two ring_fifo instances with identical stimulus.
//   dut_a: DEPTH=16, OVERWRITE=1, AFULL_LVL=8
//   dut_b: DEPTH=5,  OVERWRITE=0, AFULL_LVL=3 (the default DEPTH-2)
// Both use AEMPTY_LVL=2 and WIDTH=16.
// The driver steps a queue-based reference model for each instance at the
// moment it applies the inputs, and pushes the word each read should return.
// A separate monitor checks every cycle, one time step after the clock edge.
module tb_ring_fifo;

  localparam int W = 16;

  typedef logic [W-1:0] word_t;
  typedef word_t word_q_t[$];

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic  write, read, clear, err_clr;
  word_t data_in;

  ring_fifo_if #(.WIDTH(W), .DEPTH(16)) bus_a ();
  ring_fifo_if #(.WIDTH(W), .DEPTH(5))  bus_b ();

  assign bus_a.write   = write;
  assign bus_a.data_in = data_in;
  assign bus_a.read    = read;
  assign bus_a.clear   = clear;
  assign bus_a.err_clr = err_clr;
  assign bus_b.write   = write;
  assign bus_b.data_in = data_in;
  assign bus_b.read    = read;
  assign bus_b.clear   = clear;
  assign bus_b.err_clr = err_clr;

  ring_fifo #(.WIDTH(W), .DEPTH(16), .OVERWRITE(1), .AFULL_LVL(8), .AEMPTY_LVL(2))
    dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));

  ring_fifo #(.WIDTH(W), .DEPTH(5), .OVERWRITE(0), .AFULL_LVL(3), .AEMPTY_LVL(2))
    dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));

  // ---------------- reference model + scoreboard ----------------
  word_q_t mq_a, mq_b;      // model contents, head at index 0
  word_q_t exp_a, exp_b;    // expected read results, one per read edge
  bit      ovf_a, unf_a, ovf_b, unf_b;
  word_t   last_a, last_b;  // last word a read returned (registered data_out)

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The effect of one clock edge, worked out from the FIFO's rules.
  task automatic model_step(ref word_q_t q, ref word_q_t exp, input int depth,
                            input bit ow, input bit wr, input word_t d,
                            input bit rd, input bit clr, input bit ec,
                            inout bit ovf, inout bit unf);
    if (ec) begin
      ovf = 1'b0;
      unf = 1'b0;
    end
    if (clr) begin
      q.delete();
    end else begin
      if (rd) begin
        if (q.size() == 0) begin
          exp.push_back('0);
          unf = 1'b1;
        end else begin
          exp.push_back(q.pop_front());
        end
      end
      if (wr) begin
        if (q.size() < depth) begin
          q.push_back(d);
        end else begin
          ovf = 1'b1;
          if (ow) begin
            void'(q.pop_front());
            q.push_back(d);
          end
        end
      end
    end
  endtask

  task automatic mon(input string tag, ref word_q_t mq, ref word_q_t eq,
                     inout word_t last, input int depth, input int af, input int ae,
                     input bit movf, input bit munf,
                     input logic [31:0] dout, input logic [31:0] cnt,
                     input logic emp, input logic ful, input logic aem,
                     input logic afl, input logic ovf, input logic unf);
    word_t e;
    if (eq.size() > 0) begin
      last = eq.pop_front();
    end
`ifdef RING_FIFO_FWFT_EN
    e = (mq.size() > 0) ? mq[0] : '0;
`else
    e = last;
`endif
    check({tag, ".data_out"},     dout, {16'h0, e});
    check({tag, ".count"},        cnt, 32'(mq.size()));
    check({tag, ".empty"},        {31'h0, emp}, {31'h0, mq.size() == 0});
    check({tag, ".full"},         {31'h0, ful}, {31'h0, mq.size() == depth});
    check({tag, ".almost_empty"}, {31'h0, aem}, {31'h0, mq.size() <= ae});
    check({tag, ".almost_full"},  {31'h0, afl}, {31'h0, mq.size() >= af});
    check({tag, ".overflow"},     {31'h0, ovf}, {31'h0, movf});
    check({tag, ".underflow"},    {31'h0, unf}, {31'h0, munf});
  endtask

  task automatic mon_both();
    mon("a", mq_a, exp_a, last_a, 16, 8, 2, ovf_a, unf_a,
        32'(bus_a.data_out), 32'(bus_a.count), bus_a.empty, bus_a.full,
        bus_a.almost_empty, bus_a.almost_full, bus_a.overflow, bus_a.underflow);
    mon("b", mq_b, exp_b, last_b, 5, 3, 2, ovf_b, unf_b,
        32'(bus_b.data_out), 32'(bus_b.count), bus_b.empty, bus_b.full,
        bus_b.almost_empty, bus_b.almost_full, bus_b.overflow, bus_b.underflow);
  endtask

  // Monitor: checks one time step after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_both();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit wr, input word_t d, input bit rd, input bit clr, input bit ec);
    @(negedge clk);
    write   = wr;
    data_in = d;
    read    = rd;
    clear   = clr;
    err_clr = ec;
    model_step(mq_a, exp_a, 16, 1'b1, wr, d, rd, clr, ec, ovf_a, unf_a);
    model_step(mq_b, exp_b, 5,  1'b0, wr, d, rd, clr, ec, ovf_b, unf_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr_word(input word_t d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_word();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // An asynchronous reset in the middle of traffic. Everything returns to its
  // reset value at once, and the outputs are checked before the next edge.
  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    write = 1'b0; read = 1'b0; clear = 1'b0; err_clr = 1'b0;
    mq_a.delete(); mq_b.delete(); exp_a.delete(); exp_b.delete();
    ovf_a = 1'b0; unf_a = 1'b0; ovf_b = 1'b0; unf_b = 1'b0;
    last_a = '0; last_b = '0;
    #1;
    mon_both();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    write = 1'b0; read = 1'b0; clear = 1'b0; err_clr = 1'b0; data_in = '0;
    last_a = '0; last_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Basic order: three writes, then three reads.
    wr_word(16'h11); wr_word(16'h22); wr_word(16'h33);
    repeat (3) rd_word();
    idle(1);

    // 17 writes. dut_a overwrites its oldest entry; dut_b drops the excess.
    for (int i = 0; i <= 16; i++) wr_word(word_t'(i));
    repeat (16) rd_word();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);   // err_clr
    idle(1);

    // Drop policy on dut_b: 0xA5 is dropped.
    for (int i = 0; i < 6; i++) wr_word(16'hA0 + word_t'(i));
    repeat (6) rd_word();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Read and write together on an empty FIFO: underflow, and the write is still accepted.
    cyc(1'b1, 16'h5A, 1'b1, 1'b0, 1'b0);
    rd_word();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Fill to 5, then read and write together for 20 cycles across the pointer wrap.
    for (int i = 0; i < 5; i++) wr_word(16'h100 + word_t'(i));
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'h200 + word_t'(i), 1'b1, 1'b0, 1'b0);
    repeat (5) rd_word();

    // Fill to the almost_full level of dut_a, then clear with write held high.
    for (int i = 0; i < 8; i++) wr_word(16'h300 + word_t'(i));
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    idle(1);
    rd_word();   // underflow after the clear

    // err_clr and a new underflow in the same cycle: the flag stays set.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Random traffic in phases with different write/read weights.
    for (int i = 0; i < 1500; i++) begin
      int pw, pr;
      case ((i / 250) % 4)
        0: begin pw = 80; pr = 20; end
        1: begin pw = 20; pr = 80; end
        2: begin pw = 50; pr = 50; end
        default: begin pw = 95; pr = 5; end
      endcase
      if (i == 700) mid_reset();
      cyc($urandom_range(0, 99) < pw, word_t'($urandom), $urandom_range(0, 99) < pr,
          $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
    end

    // Stop traffic while the FIFOs still hold data, then reset.
    for (int i = 0; i < 6; i++) wr_word(word_t'($urandom));
    mid_reset();
    idle(2);

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
